pc_sequencer: RTL and testbench

//  Parametrised program counter with next-PC selection and a return-address stack (RAS).

---
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with next-PC selection and a circular
// return-address stack. One redirect per cycle, no bubbles; Exception wins
// over Stall, Stall freezes everything else.
//
// Ras entries hold raw PCPlusInc values; alignment is applied on pop so the
// stack content is exactly what was pushed. The stack memory itself is not
// reset, because a zero count already makes every entry unreachable.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80),
  parameter int               INC       = 4,
  parameter int               ALIGN     = 2,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Exception,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic             Call,
  input  logic             Return,
  input  logic [WIDTH-1:0] JumpTarget,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlusInc,
  output logic [WIDTH-1:0] PrevPC,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasUnderflow
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN) - WIDTH'(1));

  logic [WIDTH-1:0] pc_q, pc_n;
  logic [WIDTH-1:0] prev_q, prev_n;
  logic             uf_q, uf_n;
  logic [PW-1:0]    top_q, top_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;

  assign PCResult     = pc_q;
  assign PrevPC       = prev_q;
  assign PCPlusInc    = pc_q + WIDTH'(INC);
  assign RasEmpty     = (cnt_q == '0);
  assign RasFull      = (cnt_q == CW'(RAS_DEPTH));
  assign RasUnderflow = uf_q;

  // Neighbouring stack slots, wrapping modulo RAS_DEPTH (need not be a power of two).
  always_comb begin
    top_inc = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + PW'(1);
    top_dec = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - PW'(1);
  end

  // Next-PC selection and stack bookkeeping in priority order.
  always_comb begin
    pc_n   = pc_q;
    prev_n = prev_q;
    uf_n   = 1'b0;
    top_n  = top_q;
    cnt_n  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (Exception) begin
      pc_n   = EXC_VEC;
      prev_n = pc_q;
      cnt_n  = '0;
    end else if (!Stall) begin
      prev_n = pc_q;
      if (Return) begin
        if (RasEmpty) begin
          pc_n = EXC_VEC;
          uf_n = 1'b1;
        end else begin
          pc_n = ras_mem[top_q] & ALIGN_MASK;
          if (Call) begin
            // pop and push in one cycle: overwrite the top in place
            wr_en  = 1'b1;
            wr_idx = top_q;
          end else begin
            top_n = top_dec;
            cnt_n = cnt_q - CW'(1);
          end
        end
      end else if (Jump) begin
        pc_n = JumpTarget & ALIGN_MASK;
        if (Call) begin
          // when full the slot after top is the oldest entry, so it gets overwritten
          wr_en  = 1'b1;
          wr_idx = top_inc;
          top_n  = top_inc;
          if (!RasFull) cnt_n = cnt_q + CW'(1);
        end
      end else if (BranchTaken) begin
        pc_n = BranchTarget & ALIGN_MASK;
      end else begin
        pc_n = PCPlusInc;
      end
    end
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q   <= RESET_VEC;
      prev_q <= '0;
      uf_q   <= 1'b0;
      top_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_n;
      prev_q <= prev_n;
      uf_q   <= uf_n;
      top_q  <= top_n;
      cnt_q  <= cnt_n;
    end
  end

  // Stack storage write port.
  always_ff @(posedge Clk) begin
    if (!Reset && wr_en) ras_mem[wr_idx] <= PCPlusInc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives one cycle at a time from a reference model that
// keeps the return stack as a queue; expected post-edge state is queued when
// the stimulus is applied and compared after the clock edge.
module tb_pc_sequencer;

  localparam logic [31:0] EXC = 32'h80;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Exception = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        Jump = 1'b0;
  logic        Call = 1'b0;
  logic        Return = 1'b0;
  logic [31:0] JumpTarget = '0;
  logic [31:0] PCResult;
  logic [31:0] PCPlusInc;
  logic [31:0] PrevPC;
  logic        RasEmpty;
  logic        RasFull;
  logic        RasUnderflow;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .Exception    (Exception),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .Call         (Call),
    .Return       (Return),
    .JumpTarget   (JumpTarget),
    .PCResult     (PCResult),
    .PCPlusInc    (PCPlusInc),
    .PrevPC       (PrevPC),
    .RasEmpty     (RasEmpty),
    .RasFull      (RasFull),
    .RasUnderflow (RasUnderflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] prev;
    logic        emp;
    logic        full;
    logic        uf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc;
  logic [31:0] m_prev;
  logic        m_uf;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // One clock: apply inputs, advance the model, queue and compare.
  task automatic step(input logic rst, input logic st, input logic ex,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic cl, input logic rt,
                      input logic [31:0] jt);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Stall = st; Exception = ex; BranchTaken = br; BranchTarget = bt;
    Jump = jp; Call = cl; Return = rt; JumpTarget = jt;
    m_uf = 1'b0;
    if (rst) begin
      m_pc = 32'h0; m_prev = 32'h0; m_ras.delete();
    end else if (ex) begin
      m_prev = m_pc; m_pc = EXC; m_ras.delete();
    end else if (!st) begin
      m_prev = m_pc;
      if (rt) begin
        if (m_ras.size() == 0) begin
          m_pc = EXC; m_uf = 1'b1;
        end else begin
          m_pc = m_ras.pop_back() & ~32'h3;
          if (cl) m_ras.push_back(m_prev + 32'd4);
        end
      end else if (jp) begin
        m_pc = jt & ~32'h3;
        if (cl) begin
          if (m_ras.size() == 4) void'(m_ras.pop_front());
          m_ras.push_back(m_prev + 32'd4);
        end
      end else if (br) begin
        m_pc = bt & ~32'h3;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.prev = m_prev; e.emp = (m_ras.size() == 0);
    e.full = (m_ras.size() == 4); e.uf = m_uf;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc", PCResult, e.pc);
      chk("prev", PrevPC, e.prev);
      chk("empty", {31'd0, RasEmpty}, {31'd0, e.emp});
      chk("full", {31'd0, RasFull}, {31'd0, e.full});
      chk("uflow", {31'd0, RasUnderflow}, {31'd0, e.uf});
      chk("pcplus", PCPlusInc, e.pc + 32'd4);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic jump(input logic [31:0] t);
    step(0, 0, 0, 0, 0, 1, 0, 0, t);
  endtask
  task automatic call(input logic [31:0] t);
    step(0, 0, 0, 0, 0, 1, 1, 0, t);
  endtask
  task automatic ret();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    m_pc = 0; m_prev = 0; m_uf = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_empty", {31'd0, RasEmpty}, 32'd1);

    // T1: reset from 0x40, then sequential
    jump(32'h40);
    chk("t1_pre", PCResult, 32'h40);
    step(1, 0, 1, 1, 32'h500, 1, 1, 1, 32'h600);
    chk("t1_pc0", PCResult, 32'h0);
    chk("t1_prev0", PrevPC, 32'h0);
    idle(); chk("t1_pc1", PCResult, 32'h4); chk("t1_prev1", PrevPC, 32'h0);
    idle(); chk("t1_pc2", PCResult, 32'h8); chk("t1_prev2", PrevPC, 32'h4);
    idle(); chk("t1_pc3", PCResult, 32'hC); chk("t1_prev3", PrevPC, 32'h8);

    // T2: stalled jump is dropped
    jump(32'h10);
    step(0, 1, 0, 0, 0, 1, 0, 0, 32'h100);
    step(0, 1, 0, 0, 0, 1, 0, 0, 32'h100);
    chk("t2_hold", PCResult, 32'h10);
    idle(); chk("t2_seq", PCResult, 32'h14);

    // T3: nested call / return
    jump(32'h20);
    call(32'h200); chk("t3_c1", PCResult, 32'h200);
    call(32'h300); chk("t3_c2", PCResult, 32'h300);
    ret();         chk("t3_r1", PCResult, 32'h204);
    ret();         chk("t3_r2", PCResult, 32'h24);
    chk("t3_empty", {31'd0, RasEmpty}, 32'd1);

    // T4: overflow overwrites oldest, then underflow
    jump(32'h0);
    call(32'h10); call(32'h20); call(32'h30); call(32'h40); call(32'h50);
    chk("t4_full", {31'd0, RasFull}, 32'd1);
    ret(); chk("t4_p1", PCResult, 32'h44);
    ret(); chk("t4_p2", PCResult, 32'h34);
    ret(); chk("t4_p3", PCResult, 32'h24);
    ret(); chk("t4_p4", PCResult, 32'h14);
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'h700);
    chk("t4_exc", PCResult, EXC);
    chk("t4_uf", {31'd0, RasUnderflow}, 32'd1);
    chk("t4_nopush", {31'd0, RasEmpty}, 32'd1);
    idle(); chk("t4_uf_pulse", {31'd0, RasUnderflow}, 32'd0);

    // T5: exception beats stall and jump, flushes stack
    call(32'h400); call(32'h500);
    step(0, 1, 1, 0, 0, 1, 0, 0, 32'h900);
    chk("t5_pc", PCResult, EXC);
    chk("t5_prev", PrevPC, 32'h500);
    chk("t5_empty", {31'd0, RasEmpty}, 32'd1);

    // T6: alignment, wrap, call+return
    step(0, 0, 0, 1, 32'h103, 0, 0, 0, 0);
    chk("t6_align", PCResult, 32'h100);
    jump(32'hFFFF_FFFC);
    idle(); chk("t6_wrap", PCResult, 32'h0);
    call(32'h300);
    step(0, 0, 0, 0, 0, 1, 1, 1, 32'h800);
    chk("t6_cr_pc", PCResult, 32'h4);
    chk("t6_cr_cnt", {31'd0, RasEmpty}, 32'd0);
    ret(); chk("t6_cr_top", PCResult, 32'h304);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("t6_stall_uf", {31'd0, RasUnderflow}, 32'd0);

    // mixed random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 14) == 0), ($urandom_range(0, 2) == 0), $urandom(),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 3) == 0), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
